// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the MDU issue controller.
//   - E-stage MD op codes as seen on e_md_op
//   - MDU select codes driven on mdu_select, including the idle code
//   - Default latencies and the controller FSM states
//   - The decoded-op record produced by mdu_op_decode
package mdu_issue_ctrl_pkg;

  localparam int         MUL_LAT_DEF  = 5;
  localparam int         DIV_LAT_DEF  = 10;
  localparam logic [4:0] IDLE_SEL_DEF = 5'd31;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  localparam logic [4:0] SEL_MULT  = 5'd0;
  localparam logic [4:0] SEL_MULTU = 5'd1;
  localparam logic [4:0] SEL_DIV   = 5'd2;
  localparam logic [4:0] SEL_DIVU  = 5'd3;
  localparam logic [4:0] SEL_MTLO  = 5'd4;
  localparam logic [4:0] SEL_MTHI  = 5'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Classification of the E-stage op. sel is only meaningful for start/move
  // ops; lat is only meaningful for start ops.
  typedef struct packed {
    logic       md_any;
    logic       md_start;
    logic       md_move;
    logic       is_div;
    logic [4:0] sel;
    logic [3:0] lat;
  } md_dec_t;

endpackage

// File: rtl/mdu_issue_ctrl_op_decode.sv
// mdu_op_decode: combinational decode of the E-stage MD op.
// Ports:
//   valid  in   E-stage instruction valid
//   op     in   4-bit MD op code
//   dec    out  {md_any, md_start, md_move, is_div, sel, lat}
module mdu_op_decode
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int         MUL_LAT  = MUL_LAT_DEF,
  parameter int         DIV_LAT  = DIV_LAT_DEF,
  parameter logic [4:0] IDLE_SEL = IDLE_SEL_DEF
) (
  input  logic       valid,
  input  logic [3:0] op,
  output md_dec_t    dec
);

  // NOTE: every field gets a default before the case so no path leaves a
  // field unassigned; otherwise synthesis infers a latch.
  always_comb begin
    dec     = '0;
    dec.sel = IDLE_SEL;
    case (md_op_e'(op))
      MD_MULT:  begin dec.md_start = 1'b1; dec.sel = SEL_MULT;  dec.lat = 4'(MUL_LAT); end
      MD_MULTU: begin dec.md_start = 1'b1; dec.sel = SEL_MULTU; dec.lat = 4'(MUL_LAT); end
      MD_DIV:   begin dec.md_start = 1'b1; dec.sel = SEL_DIV;   dec.lat = 4'(DIV_LAT); dec.is_div = 1'b1; end
      MD_DIVU:  begin dec.md_start = 1'b1; dec.sel = SEL_DIVU;  dec.lat = 4'(DIV_LAT); dec.is_div = 1'b1; end
      MD_MTHI:  begin dec.md_move  = 1'b1; dec.sel = SEL_MTHI; end
      MD_MTLO:  begin dec.md_move  = 1'b1; dec.sel = SEL_MTLO; end
      default:  ;
    endcase
    // mfhi/mflo only take part in stalling, so they are md_any without a class.
    dec.md_any   = valid & (op >= 4'd1) & (op <= 4'd8);
    dec.md_start = valid & dec.md_start;
    dec.md_move  = valid & dec.md_move;
    dec.is_div   = valid & dec.is_div;
  end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issue/sequencing controller between the E stage and the
// HI/LO multiply-divide unit.
//   - decodes the E-stage MD op and drives MDU start/select/operands
//   - stalls MD-class ops while an operation is in flight
//   - shadows MDU latency with a 4-bit counter; lat_err flags disagreement
//     with mdu_busy (sticky until reset)
//   - suppresses issue on flush
// Optional build macro MDU_DIV0_GUARD_EN: div/divu with a zero divisor is not
// issued; done still pulses the following cycle and HI/LO are untouched.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   e_valid, e_md_op      E-stage op valid and MD op code
//   e_rs, e_rt            forwarded operands
//   flush                 exception/interrupt kills the E-stage op
//   mdu_busy              busy from the MDU
//   mdu_start, mdu_select MDU start (combinational) and select
//   mdu_d1, mdu_d2        operands to the MDU
//   stall                 freeze F/D/E, bubble into M
//   done                  1-cycle pulse, first cycle new HI/LO is readable
//   lat_err               sticky latency mismatch flag
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int         MUL_LAT  = MUL_LAT_DEF,
  parameter int         DIV_LAT  = DIV_LAT_DEF,
  parameter logic [4:0] IDLE_SEL = IDLE_SEL_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        flush,
  input  logic        mdu_busy,
  output logic        mdu_start,
  output logic [4:0]  mdu_select,
  output logic [31:0] mdu_d1,
  output logic [31:0] mdu_d2,
  output logic        stall,
  output logic        done,
  output logic        lat_err
);

`ifdef MDU_DIV0_GUARD_EN
  localparam bit DIV0_GUARD = 1'b1;
`else
  localparam bit DIV0_GUARD = 1'b0;
`endif

  md_dec_t    dec;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       lat_err_q, lat_err_d;
  logic       start_q;
  logic       inflight;
  logic       go;
  logic       div0_skip;

  mdu_op_decode #(
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT),
    .IDLE_SEL (IDLE_SEL)
  ) u_decode (
    .valid (e_valid),
    .op    (e_md_op),
    .dec   (dec)
  );

  assign inflight  = mdu_busy | (cnt_q != 4'd0);
  assign go        = dec.md_any & ~inflight & ~flush;
  assign div0_skip = DIV0_GUARD & go & dec.is_div & (e_rt == 32'd0);

  assign mdu_d1  = e_rs;
  assign mdu_d2  = e_rt;
  assign done    = done_q;
  assign lat_err = lat_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    mdu_start  = 1'b0;
    mdu_select = IDLE_SEL;
    // flush wins over stall: a killed op must not freeze the front end.
    stall      = dec.md_any & inflight & ~flush;
    // The MDU may raise busy one cycle late, so the edge after a start is
    // not compared.
    lat_err_d  = lat_err_q | (~start_q & ((cnt_q != 4'd0) != mdu_busy));

    if (go & dec.md_start & ~div0_skip) begin
      mdu_start  = 1'b1;
      mdu_select = dec.sel;
    end else if (go & dec.md_move) begin
      mdu_select = dec.sel;
    end

    // A guarded zero-divide completes immediately without touching HI/LO.
    if (div0_skip) done_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (mdu_start) begin
          cnt_d   = dec.lat;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      done_q    <= 1'b0;
      lat_err_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      lat_err_q <= lat_err_d;
      start_q   <= mdu_start;
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl. Contains a behavioural MDU (HI/LO,
// busy) and a cycle-time model of the controller rules; a negedge process
// compares every DUT output against the model each cycle after reset, and
// directed scenarios add hand-computed literal expectations.
// Honours MDU_DIV0_GUARD_EN for the zero-divisor expectations.
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

`ifdef MDU_DIV0_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs, e_rt;
  logic        flush;
  logic        mdu_busy;
  logic        mdu_start;
  logic [4:0]  mdu_select;
  logic [31:0] mdu_d1, mdu_d2;
  logic        stall, done, lat_err;

  int total = 0;
  int bad   = 0;

  mdu_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .e_valid    (e_valid),
    .e_md_op    (e_md_op),
    .e_rs       (e_rs),
    .e_rt       (e_rt),
    .flush      (flush),
    .mdu_busy   (mdu_busy),
    .mdu_start  (mdu_start),
    .mdu_select (mdu_select),
    .mdu_d1     (mdu_d1),
    .mdu_d2     (mdu_d2),
    .stall      (stall),
    .done       (done),
    .lat_err    (lat_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural MDU ----------------
  int          mdu_cnt = 0;
  logic [4:0]  p_sel;
  logic [31:0] p_a, p_b;
  logic [31:0] hi = '0, lo = '0;
  bit          force_idle = 1'b0;

  assign mdu_busy = (mdu_cnt != 0) && !force_idle;

  function automatic logic [63:0] mdu_calc(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (sel)
      5'd0: return 64'(sa * sb);
      5'd1: return {32'd0, a} * {32'd0, b};
      5'd2: if (b == 0) return {a, 32'hFFFF_FFFF};
            else return {32'(ia % ib), 32'(ia / ib)};
      5'd3: if (b == 0) return {a, 32'hFFFF_FFFF};
            else return {a % b, a / b};
      default: return {hi, lo};
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mdu_cnt <= 0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (mdu_start === 1'b1) begin
        mdu_cnt <= (mdu_select <= 5'd1) ? 5 : 10;
        p_sel   <= mdu_select;
        p_a     <= mdu_d1;
        p_b     <= mdu_d2;
      end else if (mdu_cnt != 0) begin
        mdu_cnt <= mdu_cnt - 1;
        if (mdu_cnt == 1) {hi, lo} <= mdu_calc(p_sel, p_a, p_b);
      end
      if (mdu_start !== 1'b1 && mdu_select == 5'd5) hi <= mdu_d1;
      else if (mdu_start !== 1'b1 && mdu_select == 5'd4) lo <= mdu_d1;
    end
  end

  // ---------------- controller model (cycle-time based) ----------------
  int cyc        = 0;
  int ready_cyc  = 0;   // first cycle with no shadow latency outstanding
  int done_cyc   = -1;  // cycle in which done must be high
  int last_start = -10;
  bit exp_lat_err = 1'b0;
  bit model_ok    = 1'b0;
  bit m_start, m_div0, m_shadow, m_busy;
  int m_lat;

  always @(negedge clk) begin
    logic [3:0] op;
    bit any, st, mv, shadow, inflight, go, dz, es, est;
    logic [4:0] esel;
    op       = e_md_op;
    any      = e_valid && op >= 1 && op <= 8;
    st       = e_valid && op >= 1 && op <= 4;
    mv       = e_valid && (op == 5 || op == 6);
    shadow   = cyc < ready_cyc;
    inflight = mdu_busy || shadow;
    go       = any && !inflight && !flush;
    dz       = GUARD && go && (op == 3 || op == 4) && e_rt == 0;
    es       = go && st && !dz;
    esel     = es ? 5'(op - 4'd1) : (go && mv) ? ((op == 5) ? 5'd5 : 5'd4) : 5'd31;
    est      = any && inflight && !flush;
    m_start  <= es;
    m_div0   <= dz;
    m_shadow <= shadow;
    m_busy   <= mdu_busy;
    m_lat    <= (op <= 2) ? 5 : 10;
    if (model_ok) begin
      check("mdu_start", mdu_start, es);
      check("mdu_select", mdu_select, esel);
      check("stall", stall, est);
      check("done", done, cyc == done_cyc);
      check("lat_err", lat_err, exp_lat_err);
      check("mdu_d1", mdu_d1, e_rs);
      check("mdu_d2", mdu_d2, e_rt);
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      model_ok    <= 1'b1;
      ready_cyc   <= 0;
      done_cyc    <= -1;
      exp_lat_err <= 1'b0;
      last_start  <= -10;
    end else if (model_ok) begin
      if (m_start) begin
        ready_cyc  <= cyc + m_lat + 1;
        done_cyc   <= cyc + m_lat + 1;
        last_start <= cyc;
      end
      if (m_div0) done_cyc <= cyc + 1;
      if ((m_shadow != m_busy) && (cyc != last_start + 1)) exp_lat_err <= 1'b1;
    end
    cyc <= cyc + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input bit fl);
    @(posedge clk); #1;
    reset = 1'b0; e_valid = v; e_md_op = op; e_rs = rs; e_rt = rt; flush = fl;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b1; e_valid = 1'b0; e_md_op = 4'd0; e_rs = '0; e_rt = '0; flush = 1'b0;
    end
  endtask

  // Present an op and hold it until the controller stops stalling it.
  task automatic hold_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output int stalls);
    bit fin;
    stalls = 0;
    fin    = 1'b0;
    drive(1'b1, op, rs, rt, 1'b0);
    while (!fin) begin
      settle();
      if (stall !== 1'b1) fin = 1'b1;
      else begin
        stalls++;
        if (stalls > 40) begin
          total++; bad++;
          $display("FAIL hold_timeout: op %0d still stalled after %0d cycles", op, stalls);
          fin = 1'b1;
        end
      end
    end
  endtask

  // Idle cycles until done; the first n_flush cycles flush, the first n_force
  // cycles hold mdu_busy low. Returns the cycle index (from 1) where done shows.
  task automatic wait_done(input int n_flush, input int n_force, output int n);
    bit fin;
    n   = 0;
    fin = 1'b0;
    while (!fin) begin
      n++;
      drive(1'b0, 4'd0, '0, '0, n <= n_flush);
      force_idle = (n <= n_force);
      settle();
      if (done === 1'b1) fin = 1'b1;
      else if (n > 40) begin
        total++; bad++;
        $display("FAIL done_timeout: no done within %0d cycles", n);
        fin = 1'b1;
      end
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int s, n;
    logic [31:0] hi_k, lo_k;
    reset = 1'b1; e_valid = 1'b0; e_md_op = '0; e_rs = '0; e_rt = '0; flush = 1'b0;
    do_reset(2);

    drive(1'b0, 4'd0, '0, '0, 1'b0); settle();
    check("rst_start", mdu_start, 0);
    check("rst_select", mdu_select, 31);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_lat_err", lat_err, 0);

    // 1: mult -3*7, dependent mflo
    hold_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, s);
    check("mult_issue_stalls", s, 0);
    check("mult_start", mdu_start, 1);
    check("mult_select", mdu_select, 0);
    hold_op(MD_MFLO, '0, '0, s);
    check("mflo_stalls", s, 5);
    check("mult_done", done, 1);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    check("mult_hi", hi, 32'hFFFF_FFFF);

    // 2: back-to-back divu
    hold_op(MD_DIVU, 32'd100, 32'd7, s);
    check("divu1_stalls", s, 0);
    hold_op(MD_DIVU, 32'd9, 32'd2, s);
    check("divu2_stalls", s, 10);
    check("divu2_start", mdu_start, 1);
    check("divu2_select", mdu_select, 3);
    hold_op(MD_MFHI, '0, '0, s);
    check("mfhi_stalls", s, 10);
    check("divu_hi", hi, 1);
    check("divu_lo", lo, 4);

    // 3: moves while idle, idle select, invalid op
    drive(1'b0, MD_MULT, 32'd1, 32'd1, 1'b0); settle();
    check("invalid_start", mdu_start, 0);
    check("invalid_select", mdu_select, 31);
    drive(1'b1, MD_MTHI, 32'hDEAD_BEEF, '0, 1'b0); settle();
    check("mthi_select", mdu_select, 5);
    check("mthi_start", mdu_start, 0);
    drive(1'b1, MD_MTLO, 32'h1234_5678, '0, 1'b0); settle();
    check("mtlo_select", mdu_select, 4);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    drive(1'b0, 4'd0, '0, '0, 1'b0); settle();
    check("idle_select", mdu_select, 31);
    check("mtlo_lo", lo, 32'h1234_5678);

    // 4: flush coincident with issue, then flush during a div RUN
    hi_k = hi; lo_k = lo;
    drive(1'b1, MD_MULT, 32'd6, 32'd6, 1'b1); settle();
    check("flush_start", mdu_start, 0);
    check("flush_stall", stall, 0);
    drive(1'b0, 4'd0, '0, '0, 1'b0); settle();
    check("flush_hi_kept", hi, hi_k);
    check("flush_lo_kept", lo, lo_k);
    hold_op(MD_DIV, 32'd50, 32'd5, s);
    check("div_after_flush_stalls", s, 0);
    wait_done(3, 0, n);
    check("div_flushed_done_cycle", n, 11);
    check("div_flushed_lo", lo, 10);
    check("div_flushed_hi", hi, 0);

    // 5: reset mid-RUN at cnt=3
    hold_op(MD_DIV, 32'd1000, 32'd3, s);
    for (int i = 0; i < 7; i++) drive(1'b0, 4'd0, '0, '0, 1'b0);
    do_reset(1);
    drive(1'b1, MD_MFLO, '0, '0, 1'b0); settle();
    check("rstrun_stall", stall, 0);
    check("rstrun_done", done, 0);
    check("rstrun_lat_err", lat_err, 0);

    // 6: zero divisor
    drive(1'b0, 4'd0, '0, '0, 1'b0); settle();
    hi_k = hi; lo_k = lo;
    hold_op(MD_DIV, 32'd7, 32'd0, s);
    check("div0_stalls", s, 0);
    if (GUARD) begin
      check("div0_start", mdu_start, 0);
      check("div0_select", mdu_select, 31);
      drive(1'b0, 4'd0, '0, '0, 1'b0); settle();
      check("div0_done", done, 1);
      check("div0_hi_kept", hi, hi_k);
      check("div0_lo_kept", lo, lo_k);
    end else begin
      check("div0_start", mdu_start, 1);
      check("div0_select", mdu_select, 2);
      wait_done(0, 0, n);
      check("div0_done_cycle", n, 11);
    end

    // lat_err: busy forced low during a mult RUN
    drive(1'b0, 4'd0, '0, '0, 1'b0); settle();
    hold_op(MD_MULT, 32'd2, 32'd3, s);
    wait_done(0, 3, n);
    check("laterr_done_cycle", n, 6);
    check("laterr_set", lat_err, 1);
    check("laterr_lo", lo, 6);
    drive(1'b0, 4'd0, '0, '0, 1'b0); settle();
    check("laterr_sticky", lat_err, 1);
    do_reset(1);
    drive(1'b0, 4'd0, '0, '0, 1'b0); settle();
    check("laterr_cleared", lat_err, 0);

    drive(1'b0, 4'd0, '0, '0, 1'b0); settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
